fc_feature_buffer: RTL and testbench
====================================

// Module: fc_feature_buffer
// PURPOSE
//  Flatten buffer between the last pooling stage and the 400->120 fully connected layer.
//  Captures one complete pooled feature map (16x5x5 = INPUT_SIZE words) from a valid/ready stream.
//  Replays the map to the FC layer as an indexed valid/ready stream, so FC can apply weight[index].
//  Single frame buffer, so fill and drain alternate. Reports a framing error when the in_last marker disagrees with the word count.
// PARAMETERS
//  DATA_WIDTH  12   width of one signed fixed-point feature word
//  INPUT_SIZE  400  words per frame; must be >= 2
//  ADDR_WIDTH  9    index width; must satisfy 2**ADDR_WIDTH >= INPUT_SIZE
// PORTS
//  clk        in   1           single clock; all logic on its rising edge
//  rst_n      in   1           reset, synchronous, active-low
//  in_valid   in   1           upstream word valid
//  in_data    in   DATA_WIDTH  upstream feature word (passed through bit-exact)
//  in_last    in   1           upstream marks the final word of the frame
//  in_ready   out  1           buffer accepts a word this cycle
//  out_valid  out  1           out_data/out_index valid
//  out_data   out  DATA_WIDTH  feature word to the FC layer
//  out_index  out  ADDR_WIDTH  position of out_data within the frame, 0..INPUT_SIZE-1
//  out_last   out  1           high with the word at index INPUT_SIZE-1
//  out_ready  in   1           FC layer accepts the word
//  frame_done out  1           one-cycle pulse after the final output handshake
//  err_len    out  1           sticky framing error flag
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge):
//   - state=FILL; write and read pointers = 0.
//   - out_valid=0, out_data=0, out_index=0, out_last=0, frame_done=0, err_len=0.
//   - in_ready=0 during the reset cycle and 1 from the first cycle after reset.
//   - Storage contents are not cleared. Reset applied mid-frame abandons that frame.
//  State FILL:
//   - in_ready=1, out_valid=0.
//   - A handshake (in_valid & in_ready) writes in_data to mem[wr_ptr], then wr_ptr++.
//   - Gaps in in_valid are allowed; no state change occurs during a gap.
//   - On the handshake at wr_ptr=INPUT_SIZE-1: wr_ptr wraps to 0 and the next state is LOAD.
//   - Framing check on each handshake:
//     - in_last=1 at wr_ptr!=INPUT_SIZE-1 sets err_len.
//     - in_last=0 at wr_ptr=INPUT_SIZE-1 sets err_len.
//     - Frame length is always set by the count; in_last never ends or extends a frame.
//  State LOAD (exactly 1 cycle):
//   - in_ready=0, out_valid=0.
//   - Registers out_data=mem[0], out_index=0, out_last=0.
//   - Next state is DRAIN with out_valid=1.
//   - Latency: out_valid is first high 2 cycles after the cycle of the final input handshake.
//  State DRAIN:
//   - in_ready=0.
//   - out_data, out_index and out_last stay stable while out_valid & !out_ready.
//   - Handshake at index i<INPUT_SIZE-1: next cycle presents mem[i+1], index i+1 (zero-bubble; 1 word/cycle when out_ready=1).
//   - out_last=1 exactly when out_index=INPUT_SIZE-1.
//   - Handshake at INPUT_SIZE-1: next cycle out_valid=0, out_last=0, frame_done=1 for 1 cycle, state=FILL.
//   - in_ready=1 in that same cycle, so a new frame may start immediately.
//  err_len:
//   - Once set, stays 1 until reset; frames are not aborted.
//   - Evaluated only in FILL; in_last is ignored in all other states.
//  Arithmetic: no data modification; pointer compares use INPUT_SIZE-1 exactly. No out-of-range index is ever produced.
// TESTING
//  T1 Fill 400 words with in_data=k (k=0..399), in_last on k=399, out_ready=1:
//     -> 400 outputs with out_data=out_index=k, out_last only at 399, frame_done 1 cycle later, err_len=0.
//  T2 Latency: final input handshake in cycle c -> out_valid=0 in cycle c+1; out_valid=1 with index 0 in cycle c+2.
//  T3 Backpressure: out_ready toggled randomly, plus held low 10 cycles at index 57
//     -> index 57 data held stable; no words dropped or duplicated; order 0..399.
//  T4 Input gaps: in_valid=1 every 3rd cycle -> stored order intact; in_ready=0 throughout DRAIN; words offered during DRAIN are not accepted.
//  T5 in_last on word 199 of a frame -> err_len=1 from the next cycle; frame still drains 400 words; err_len still 1 after a clean second frame.
//  T6 rst_n=0 for 1 cycle at output index 120, then a fresh frame of 400 words (k+1000)
//     -> all outputs 0 after reset, err_len=0; output sequence 1000..1399 from index 0.
// T7 Back-to-back frames: two frames, the second starting the cycle frame_done is high -> both streams correct, no bubble at the input.

Source files
------------

// File: rtl/fc_feature_buffer_if.sv
// Stream bundle between the pooling stage, the flatten buffer and the FC layer.
// Handshake rule for both streams: a word moves on a rising edge where valid and
// ready are both high; the sender holds data/index/last stable while valid is
// high and ready is low, and valid never depends combinationally on ready.
interface fc_feature_buffer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 9
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_ready;

  // Environment side: drives the input stream and the FC-side ready.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fc_feature_buffer.sv
// Flatten buffer: captures one full pooled feature map, then replays it to the
// FC layer as an indexed stream. Single frame store, so fill and drain alternate.
// err_len flags any frame whose in_last marker disagrees with the word count.
module fc_feature_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int INPUT_SIZE = 400,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc_feature_buffer_if.slave   bus,
  output logic                 frame_done,
  output logic                 err_len,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INPUT_SIZE - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic                  in_ready_n;
  logic                  out_valid_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic [ADDR_WIDTH-1:0] out_index_n;
  logic                  out_last_n;
  logic                  frame_done_n;
  logic                  err_len_n;
  logic                  mem_we;
  logic                  in_fire;
  logic                  out_fire;
  logic [ADDR_WIDTH-1:0] next_index;

  logic [DATA_WIDTH-1:0] mem [0:INPUT_SIZE-1];

  assign in_fire    = bus.in_valid & bus.in_ready;
  assign out_fire   = bus.out_valid & bus.out_ready;
  assign next_index = bus.out_index + 1'b1;
  assign dbg_state  = state;

  // Next-state and next-output logic; the read pointer is out_index itself.
  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    out_valid_n  = bus.out_valid;
    out_data_n   = bus.out_data;
    out_index_n  = bus.out_index;
    out_last_n   = bus.out_last;
    frame_done_n = 1'b0;
    err_len_n    = err_len;
    mem_we       = 1'b0;
    case (state)
      FILL: begin
        if (in_fire) begin
          mem_we = 1'b1;
          if (wr_ptr == LAST_IDX) begin
            wr_ptr_n = '0;
            state_n  = LOAD;
            if (!bus.in_last) err_len_n = 1'b1;
          end else begin
            wr_ptr_n = wr_ptr + 1'b1;
            if (bus.in_last) err_len_n = 1'b1;
          end
        end
      end
      LOAD: begin
        // Prime the output register with word 0 so draining has no bubble.
        out_valid_n = 1'b1;
        out_data_n  = mem[0];
        out_index_n = '0;
        out_last_n  = 1'b0;
        state_n     = DRAIN;
      end
      DRAIN: begin
        if (out_fire) begin
          if (bus.out_index == LAST_IDX) begin
            out_valid_n  = 1'b0;
            out_last_n   = 1'b0;
            out_data_n   = '0;
            out_index_n  = '0;
            frame_done_n = 1'b1;
            state_n      = FILL;
          end else begin
            out_index_n = next_index;
            out_data_n  = mem[next_index];
            out_last_n  = (next_index == LAST_IDX);
          end
        end
      end
      default: state_n = FILL;
    endcase
    // Registered ready: open exactly in cycles spent in FILL.
    in_ready_n = (state_n == FILL);
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FILL;
      wr_ptr        <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
      frame_done    <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      state         <= state_n;
      wr_ptr        <= wr_ptr_n;
      bus.in_ready  <= in_ready_n;
      bus.out_valid <= out_valid_n;
      bus.out_data  <= out_data_n;
      bus.out_index <= out_index_n;
      bus.out_last  <= out_last_n;
      frame_done    <= frame_done_n;
      err_len       <= err_len_n;
    end
  end

  // Frame storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_fc_feature_buffer.sv
// Bench for fc_feature_buffer: directed frames, a frame-level reference model
// checked every cycle, and a few literal expectations on the collected stream.
module tb_fc_feature_buffer;
  localparam int DW = 12;
  localparam int N  = 400;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_done;
  logic err_len;
  logic [1:0] dbg_state;

  fc_feature_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fc_feature_buffer #(.DATA_WIDTH(DW), .INPUT_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .err_len    (err_len),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic r_q = 1'b1;   // rst_n as seen by the last rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    r_q <= rst_n;
  end

  // ---------------- counters / check helper ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Phases: 0 = collecting a frame, 1 = one dead cycle, 2 = replaying.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  int  m_phase = 0;
  int  m_cnt_in = 0;
  int  m_cnt_out = 0;
  bit  m_err = 0;
  bit  m_done_exp = 0;
  bit  m_first = 0;
  bit  started = 0;
  int  fill_end_cyc = 0;

  always @(negedge clk) begin
    if (!r_q) begin
      chk("rst_in_ready",  bus.in_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data",  bus.out_data,  0);
      chk("rst_out_index", bus.out_index, 0);
      chk("rst_out_last",  bus.out_last,  0);
      chk("rst_frame_done", frame_done,   0);
      chk("rst_err_len",   err_len,       0);
      m_phase = 0; m_cnt_in = 0; m_cnt_out = 0; m_err = 0; m_done_exp = 0; m_first = 0;
      exp_q.delete();
      out_log.delete();
      started = 1;
    end else if (started) begin
      chk("in_ready",   bus.in_ready,  (m_phase == 0));
      chk("out_valid",  bus.out_valid, (m_phase == 2));
      chk("frame_done", frame_done,    m_done_exp);
      chk("err_len",    err_len,       m_err);
      if (m_phase == 2) begin
        chk("out_index", bus.out_index, m_cnt_out);
        chk("out_last",  bus.out_last,  (m_cnt_out == N - 1));
        if (exp_q.size() > 0) chk("out_data", bus.out_data, exp_q[0]);
        else                  chk("out_unexpected", 1, 0);
        if (m_first) begin
          chk("latency", cyc - fill_end_cyc, 2);
          m_first = 0;
        end
      end
      // advance the model to what the coming edge must do
      m_done_exp = 0;
      case (m_phase)
        0: if (bus.in_valid) begin
          exp_q.push_back(bus.in_data);
          if (bus.in_last != (m_cnt_in == N - 1)) m_err = 1;
          m_cnt_in++;
          if (m_cnt_in == N) begin
            m_cnt_in = 0;
            m_phase = 1;
            fill_end_cyc = cyc;
          end
        end
        1: begin
          m_phase = 2;
          m_cnt_out = 0;
          m_first = 1;
        end
        default: if (bus.out_ready) begin
          out_log.push_back(bus.out_data);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_cnt_out++;
          if (m_cnt_out == N) begin
            m_phase = 0;
            m_done_exp = 1;
          end
        end
      endcase
    end
  end

  // ---------------- FC-side ready driver ----------------
  int rdy_mode = 0;   // 0: always ready, 1: random with a hold at index 57
  int hold57 = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      bus.out_ready = 1'b1;
    end else if (bus.out_valid && bus.out_index == 57 && hold57 < 10) begin
      bus.out_ready = 1'b0;
      hold57++;
    end else begin
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- input driver tasks ----------------
  task automatic push_word(input logic [DW-1:0] d, input logic l, output bit fd_at_accept);
    int g = 0;
    bit acc = 0;
    fd_at_accept = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!acc && g < 3000) begin
      @(posedge clk);
      acc = bus.in_ready;
      fd_at_accept = frame_done;
      g++;
    end
    if (!acc) chk("in_accept_timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input int extra_last, output bit first_fd);
    bit fd;
    for (int k = 0; k < N; k++) begin
      push_word(DW'(base + k), (k == N - 1) || (k == extra_last), fd);
      if (k == 0) first_fd = fd;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    int g = 0;
    bit seen = 0;
    while (!seen && g < 5000) begin
      @(negedge clk);
      seen = frame_done;
      g++;
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit fd;
    int g;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1/T2: ramp frame, always ready
    send_frame(0, 0, -1, fd);
    wait_done();
    chk("t1_count", out_log.size(), 400);
    chk("t1_first", out_log[0], 0);
    chk("t1_w123", out_log[123], 123);
    chk("t1_last", out_log[399], 399);
    chk("t1_err", err_len, 0);

    // T3: random backpressure with a 10-cycle hold at index 57
    out_log.delete();
    rdy_mode = 1;
    hold57 = 0;
    send_frame(500, 0, -1, fd);
    wait_done();
    rdy_mode = 0;
    chk("t3_hold57", hold57, 10);
    chk("t3_count", out_log.size(), 400);
    chk("t3_w57", out_log[57], 557);
    chk("t3_w58", out_log[58], 558);

    // T4: input every 3rd cycle, then junk offered during the drain
    out_log.delete();
    send_frame(2000, 2, -1, fd);
    bus.in_valid = 1'b1;
    bus.in_data = 12'hABC;
    bus.in_last = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    wait_done();
    chk("t4_count", out_log.size(), 400);
    chk("t4_first", out_log[0], 2000);
    chk("t4_last", out_log[399], 2399);
    chk("t4_err", err_len, 0);

    // T5: stray in_last on word 199, then a clean frame
    out_log.delete();
    send_frame(100, 0, 199, fd);
    wait_done();
    chk("t5_err_set", err_len, 1);
    chk("t5_count", out_log.size(), 400);
    send_frame(300, 0, -1, fd);
    wait_done();
    chk("t5_err_sticky", err_len, 1);

    // T6: reset while the output sits at index 120
    send_frame(0, 0, -1, fd);
    g = 0;
    while (!(bus.out_valid && bus.out_index == 120) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("t6_reached_120", bus.out_index, 120);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_frame(1000, 0, -1, fd);
    wait_done();
    chk("t6_err", err_len, 0);
    chk("t6_count", out_log.size(), 400);
    chk("t6_first", out_log[0], 1000);
    chk("t6_last", out_log[399], 1399);

    // T7: second frame starts in the frame_done cycle
    out_log.delete();
    send_frame(3000, 0, -1, fd);
    send_frame(200, 0, -1, fd);
    chk("t7_start_on_done", fd, 1);
    wait_done();
    chk("t7_count", out_log.size(), 800);
    chk("t7_f1_last", out_log[399], 3399);
    chk("t7_f2_first", out_log[400], 200);
    chk("t7_f2_last", out_log[799], 599);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    chk("global_timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
